// File: rtl/cpu_clk_switch_m.sv
// CPU phi2 clock controller for the beeb816 CPLD.
// Produces clkout either from the synchronised BBC phi0 (LS) or by dividing
// hsclk (HS), and switches between the two without runt phases. During a
// switch, clkout is parked at STOP_LEVEL.
//
// Handshake: hsclk_sel is a level request. The controller acknowledges it by
// raising hs_selected (HS_RUN) or ls_selected (LS_RUN) once the switch has
// completed. switch_busy is high while neither mode is fully selected.
module cpu_clk_switch_m #(
  parameter int unsigned DIV_W       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          STOP_LEVEL  = 1'b0,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic             hsclk,
  input  logic             resetb,
  input  logic             lsclk_in,
  input  logic             hsclk_sel,
  input  logic [DIV_W-1:0] cpuclk_div_sel,
  output logic             clkout,
  output logic             hs_selected,
  output logic             ls_selected,
  output logic             switch_busy,
  output logic [2:0]       state_dbg_o
);

  typedef enum logic [2:0] {
    LS_RUN  = 3'd0,
    LS_WAIT = 3'd1,
    HS_GAP  = 3'd2,
    HS_RUN  = 3'd3,
    LS_SYNC = 3'd4
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  state_t                 state_q, state_d;
  logic                   clkout_q, clkout_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [3:0]             gap_q, gap_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ls_d_q;
  logic                   ls_s;
  logic                   stop_edge;

  assign ls_s      = sync_q[SYNC_STAGES-1];
  // The BBC clock has just entered its stop phase: the safe point to park.
  assign stop_edge = (ls_s == STOP_LEVEL) && (ls_d_q != STOP_LEVEL);

  // Synchroniser for phi0 plus one extra flop for edge detection.
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      sync_q <= {SYNC_STAGES{STOP_LEVEL}};
      ls_d_q <= STOP_LEVEL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lsclk_in};
      ls_d_q <= ls_s;
    end
  end

  // Next-state and next-clkout for the mode-switch FSM.
  always_comb begin
    state_d  = state_q;
    clkout_d = clkout_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    gap_d    = gap_q;
    case (state_q)
      LS_RUN: begin
        clkout_d = ls_s;
        if (hsclk_sel) state_d = LS_WAIT;
      end
      LS_WAIT: begin
        if (stop_edge) begin
          clkout_d = STOP_LEVEL;
          gap_d    = GAP_LOAD;
          state_d  = HS_GAP;
        end else begin
          clkout_d = ls_s;
          if (!hsclk_sel) state_d = LS_RUN;
        end
      end
      HS_GAP: begin
        clkout_d = STOP_LEVEL;
        if (gap_q == 4'd0) begin
          if (hsclk_sel) begin
            div_d   = cpuclk_div_sel;
            cnt_d   = cpuclk_div_sel;
            state_d = HS_RUN;
          end else begin
            state_d = LS_SYNC;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      HS_RUN: begin
        if (cnt_q == '0) begin
          clkout_d = ~clkout_q;
          if (clkout_q != STOP_LEVEL) begin
            // Returning to the stop level: only here may the divider or the
            // mode change, so the non-stop phase always completes.
            div_d = cpuclk_div_sel;
            cnt_d = cpuclk_div_sel;
            if (!hsclk_sel) state_d = LS_SYNC;
          end else begin
            cnt_d = div_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LS_SYNC: begin
        clkout_d = STOP_LEVEL;
        if (stop_edge) state_d = LS_RUN;
      end
      default: begin
        clkout_d = STOP_LEVEL;
        state_d  = LS_RUN;
      end
    endcase
  end

  // FSM state, registered clkout and counters.
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= LS_RUN;
      clkout_q <= STOP_LEVEL;
      cnt_q    <= '0;
      div_q    <= '0;
      gap_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      clkout_q <= clkout_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      gap_q    <= gap_d;
    end
  end

  assign clkout      = clkout_q;
  assign hs_selected = (state_q == HS_RUN);
  assign ls_selected = (state_q == LS_RUN);
  assign switch_busy = !(hs_selected || ls_selected);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_cpu_clk_switch_m.sv
// Directed bench for cpu_clk_switch_m with default parameters
// (DIV_W=2, SYNC_STAGES=2, STOP_LEVEL=0, GAP_CYCLES=2).
// lsclk_in is generated as hsclk/16: high for 8 edges, then low for 8.
module tb_cpu_clk_switch_m;

  logic       hsclk = 1'b0;
  logic       resetb;
  logic       lsclk_in;
  logic       hsclk_sel;
  logic [1:0] cpuclk_div_sel;
  logic       clkout;
  logic       hs_selected;
  logic       ls_selected;
  logic       switch_busy;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;
  int n      = 0;   // index of the next hsclk rising edge since reset release
  int last   = 0;   // index of the edge just sampled

  typedef struct {
    logic       sel;
    logic [1:0] div;
    logic       clk;
    logic       hs;
    logic       ls;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[48:105];

  cpu_clk_switch_m dut (
    .hsclk          (hsclk),
    .resetb         (resetb),
    .lsclk_in       (lsclk_in),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .clkout         (clkout),
    .hs_selected    (hs_selected),
    .ls_selected    (ls_selected),
    .switch_busy    (switch_busy),
    .state_dbg_o    (state_dbg)
  );

  // Clock
  always #5 hsclk = ~hsclk;

  // lsclk_in level driven before edge k
  function automatic logic ls_at(input int k);
    if (k < 0) return 1'b0;
    return ((k % 16) < 8);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, last, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, sample 1ns after the rising edge.
  task automatic step(input logic sel, input logic [1:0] div);
    @(negedge hsclk);
    hsclk_sel      = sel;
    cpuclk_div_sel = div;
    lsclk_in       = ls_at(n);
    @(posedge hsclk);
    #1;
    last = n;
    n++;
  endtask

  task automatic fill(input int a, input int b, input logic sel, input logic [1:0] div,
                      input logic clk, input logic hs, input logic ls, input logic [2:0] st);
    for (int k = a; k <= b; k++) tbl[k] = '{sel, div, clk, hs, ls, st};
  endtask

  // Reset, request HS with the given divider, then time four HS phases.
  task automatic hs_measure(input logic [1:0] div, input int exp_half);
    int   c;
    logic prev;
    bit   got;
    resetb = 1'b0;
    @(negedge hsclk);
    resetb = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step(1'b1, div);
      if (hs_selected) got = 1'b1;
    end
    chk("hs_entry_reached", int'(got), 1);
    if (got) begin
      for (int p = 0; p < 4; p++) begin
        prev = clkout;
        c = 0;
        do begin
          step(1'b1, div);
          c++;
        end while (clkout == prev && c < 20);
        chk("hs_half_period", c, exp_half);
      end
    end
  endtask

  initial begin
    bit found;

    resetb         = 1'b0;
    lsclk_in       = 1'b0;
    hsclk_sel      = 1'b0;
    cpuclk_div_sel = 2'd0;

    // Reset state
    #12;
    chk("rst_clkout", clkout, 0);
    chk("rst_ls_selected", ls_selected, 1);
    chk("rst_hs_selected", hs_selected, 0);
    chk("rst_switch_busy", switch_busy, 0);
    chk("rst_state", state_dbg, 0);
    @(negedge hsclk);
    resetb = 1'b1;
    n = 0;

    // LS mode: clkout is lsclk_in delayed by three edges
    for (int k = 0; k < 48; k++) begin
      step(1'b0, 2'd0);
      chk("ls_follow", clkout, int'(ls_at(last - 2)));
      chk("ls_selected", ls_selected, 1);
      chk("ls_hs_selected", hs_selected, 0);
      chk("ls_busy", switch_busy, 0);
    end

    // Switch to HS (div 1), divider change 1->3 mid high, drop back to LS
    fill(48, 49, 1, 1, 0, 0, 0, 1);
    fill(50, 57, 1, 1, 1, 0, 0, 1);
    fill(58, 59, 1, 1, 0, 0, 0, 2);
    fill(60, 61, 1, 1, 0, 1, 0, 3);
    fill(62, 63, 1, 1, 1, 1, 0, 3);
    fill(64, 65, 1, 1, 0, 1, 0, 3);
    fill(66, 67, 1, 1, 1, 1, 0, 3);
    fill(68, 69, 1, 1, 0, 1, 0, 3);
    fill(70, 70, 1, 1, 1, 1, 0, 3);
    fill(71, 71, 1, 3, 1, 1, 0, 3);
    fill(72, 75, 1, 3, 0, 1, 0, 3);
    fill(76, 79, 1, 3, 1, 1, 0, 3);
    fill(80, 83, 1, 3, 0, 1, 0, 3);
    fill(84, 85, 1, 3, 1, 1, 0, 3);
    fill(86, 87, 0, 3, 1, 1, 0, 3);
    fill(88, 89, 0, 3, 0, 0, 0, 4);
    fill(90, 97, 0, 3, 0, 0, 1, 0);
    fill(98, 105, 0, 3, 1, 0, 1, 0);
    for (int k = 48; k <= 105; k++) begin
      step(tbl[k].sel, tbl[k].div);
      chk("sw_clkout", clkout, int'(tbl[k].clk));
      chk("sw_hs_selected", hs_selected, int'(tbl[k].hs));
      chk("sw_ls_selected", ls_selected, int'(tbl[k].ls));
      chk("sw_busy", switch_busy, int'(!(tbl[k].hs || tbl[k].ls)));
      chk("sw_state", state_dbg, int'(tbl[k].st));
    end

    // Short hsclk_sel pulse while lsclk_in is high: back to LS_RUN
    for (int k = 106; k < 128; k++) begin
      bit pulse;
      pulse = (n >= 113 && n <= 115);
      step(pulse, 2'd1);
      chk("pulse_clkout", clkout, int'(ls_at(last - 2)));
      chk("pulse_hs_selected", hs_selected, 0);
      chk("pulse_state", state_dbg, pulse ? 1 : 0);
      chk("pulse_busy", switch_busy, int'(pulse));
    end

    // Asynchronous reset during an HS high phase
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b1, 2'd1);
      if (hs_selected && clkout) found = 1'b1;
    end
    chk("hs_high_reached", int'(found), 1);
    #2;
    resetb = 1'b0;
    #1;
    chk("arst_clkout", clkout, 0);
    chk("arst_state", state_dbg, 0);
    chk("arst_ls_selected", ls_selected, 1);
    chk("arst_hs_selected", hs_selected, 0);
    @(negedge hsclk);
    resetb = 1'b1;
    step(1'b0, 2'd0);
    chk("rel_ls_selected", ls_selected, 1);
    chk("rel_state", state_dbg, 0);

    // Divider boundaries: div 0 -> half period 1, div 3 -> half period 4
    hs_measure(2'd0, 1);
    hs_measure(2'd3, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_clk_switch_m.md
Name: cpu_clk_switch_m

Overview:
- Parametrised next-generation CPU clock controller for the beeb816 CPLD.
- Generates the CPU phi2 clock in one of two modes:
  - low-speed (LS): follows the BBC phi0 clock, sampled and synchronised;
  - high-speed (HS): divided from hsclk by a programmable ratio.
- Switches between modes glitch-free, with a handshake, at a programmable stop level.
- Feeds cpu_ck_phi2 and the hs/ls selected flags used by the dummy-access and bus-drive logic.

Parameters:
- DIV_W, 2: width of cpuclk_div_sel. HS half-period = (div_sel+1) hsclk cycles.
- SYNC_STAGES, 2: flops in the lsclk_in synchroniser. Legal range 2..4.
- STOP_LEVEL, 0: clkout level held during switching. 0 = stop in phi1, 1 = stop in phi2.
- GAP_CYCLES, 2: hsclk cycles clkout is held at STOP_LEVEL between leaving LS and starting HS. Legal range 1..15.

Ports:
- hsclk, input, 1: single clock, high-speed oscillator.
- resetb, input, 1: asynchronous active-low reset.
- lsclk_in, input, 1: BBC phi0. Asynchronous to hsclk; treated as data.
- hsclk_sel, input, 1: 1 = request HS mode, 0 = request LS mode. Level-sensitive.
- cpuclk_div_sel, input, DIV_W: HS divide select.
- clkout, output, 1: CPU phi2 clock. Registered.
- hs_selected, output, 1: high only in HS_RUN.
- ls_selected, output, 1: high only in LS_RUN.
- switch_busy, output, 1: high in any transition state.

Behaviour:
- One clock (hsclk); asynchronous active-low reset (resetb). All state updates on the hsclk rising edge.
- Reset values:
  - state = LS_RUN;
  - clkout = STOP_LEVEL;
  - synchroniser and edge flops = STOP_LEVEL;
  - div counter = 0, div latch = 0, gap counter = 0;
  - ls_selected = 1, hs_selected = 0, switch_busy = 0.
- Synchroniser:
  - lsclk_in passes through SYNC_STAGES flops to give ls_s, plus one more flop ls_d.
  - stop_edge = (ls_s == STOP_LEVEL) & (ls_d != STOP_LEVEL).
- LS_RUN:
  - clkout <= ls_s. Latency from lsclk_in to clkout is SYNC_STAGES+1 hsclk cycles.
  - If hsclk_sel = 1, go to LS_WAIT.
- LS_WAIT:
  - clkout continues to follow ls_s.
  - On stop_edge: clkout = STOP_LEVEL, load gap counter with GAP_CYCLES-1, go to HS_GAP.
  - If hsclk_sel returns to 0 before stop_edge, go back to LS_RUN with no visible change on clkout.
- HS_GAP:
  - clkout held at STOP_LEVEL; gap counter decrements.
  - At 0:
    - if hsclk_sel = 1: latch cpuclk_div_sel into div_q, load div counter = div_q, go to HS_RUN;
    - otherwise go to LS_SYNC.
- HS_RUN:
  - Div counter decrements each cycle. At 0, clkout toggles and the counter reloads div_q.
  - The first toggle moves clkout away from STOP_LEVEL, (div_q+1) cycles after entry.
  - cpuclk_div_sel is re-latched into div_q only on a toggle that returns clkout to STOP_LEVEL. Mid-cycle changes never produce a runt phase.
  - If hsclk_sel = 0 at the moment clkout returns to STOP_LEVEL, go to LS_SYNC (clkout stays at STOP_LEVEL). A full non-stop phase always completes first.
- LS_SYNC:
  - clkout held at STOP_LEVEL.
  - Wait for stop_edge, then go to LS_RUN. This aligns the next non-stop phase to a full BBC phase.
  - If hsclk_sel is reasserted here, stay until stop_edge, then go LS_RUN → LS_WAIT normally.
- Outputs:
  - hs_selected and ls_selected are decoded from the registered state and are never both 1.
  - switch_busy = !(hs_selected | ls_selected).
- clkout must never produce a phase shorter than 1 hsclk cycle. During switching, a stop-level phase is never shorter than GAP_CYCLES (entering HS) or half an LS period (leaving HS).
- Reset mid-operation: immediate return to reset values, with clkout forced to STOP_LEVEL asynchronously.
- div_sel = 0 gives a half-period of 1, i.e. clkout = hsclk/2.
- div_sel all-ones gives a half-period of 2^DIV_W.

Test Plan:
- Reset, then run with hsclk = 16× lsclk_in and hsclk_sel = 0 → clkout follows lsclk_in delayed 3 hsclk cycles; ls_selected = 1; hs_selected = 0; switch_busy = 0.
- Assert hsclk_sel with div_sel = 1, GAP = 2 → clkout stays 0 from the LS falling edge, 2 gap cycles, then toggles every 2 hsclk cycles; hs_selected rises on HS_RUN entry; no runt phase.
- In HS_RUN, change div_sel 1 → 3 mid high phase → the current high phase remains 2 cycles; the next low phase and all following phases are 4 cycles.
- Deassert hsclk_sel mid high phase → the high phase completes; clkout stays 0 until the next synchronised lsclk falling edge; then ls_selected = 1 and clkout follows lsclk_in.
- Pulse hsclk_sel high for 3 cycles while lsclk_in is high (LS_WAIT) → returns to LS_RUN; clkout is identical to the no-pulse reference; hs_selected never 1.
- Assert resetb = 0 during HS_RUN with clkout = 1 → clkout = 0 immediately (asynchronously); on release, state is LS_RUN and ls_selected = 1.
